latency_sched: RTL
==================

Name: latency_sched

Overview:
- Programmable-delay event scheduler; runtime counterpart of the fixed-LAT delay line.
- Accepts tagged events, each with its own delay, and holds up to SLOTS of them in flight.
- Presents each event on a valid/ready output once its delay has elapsed.
- Sits between the trigger sources and the consumers that need delayed, re-timed strobes.

Parameters:
- SLOTS, 4, number of concurrent outstanding events (1..16).
- DLY_W, 8, width of per-event delay value.
- TAG_W, 4, width of event tag carried through unchanged.

Ports:
- clock  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all outstanding events.
- in_valid  in  1  event request.
- in_ready  out  1  a free slot exists; not in reset; flush low.
- in_delay  in  DLY_W  delay D for this event.
- in_tag  in  TAG_W  event tag.
- out_valid  out  1  at least one event is due.
- out_ready  in  1  consumer accepts the presented event.
- out_tag  out  TAG_W  tag of the presented event.
- out_late  out  1  presented event has been due for at least 1 prior cycle without being taken.
- busy_cnt  out  $clog2(SLOTS+1)  number of occupied slots.

Behaviour:
- Per slot, registered state: occ, cnt[DLY_W], tag, late.
- Reset (rst high at an edge): all occ=0, cnt=0, late=0.
  - While rst is high: in_ready=0, out_valid=0, out_tag=0, out_late=0, busy_cnt=0.
- Accept:
  - Occurs when in_valid && in_ready at edge k.
  - Target is the lowest-index slot with occ=0; set occ=1, cnt=in_delay, tag=in_tag, late=0.
  - in_ready is derived from registered occ only. A slot freed at edge k cannot be reused at edge k; it is available from edge k+1.
- Countdown: every edge, each occupied slot with cnt>0 decrements by 1. No wrap; cnt saturates at 0.
- Due: a slot is due when occ=1 && cnt==0.
  - Latency: accepted at edge k with delay D, the slot is due in the cycle after edge k+D.
  - D=0 gives out_valid in the cycle immediately after the accept edge.
- Output selection (combinational from registered state):
  - out_valid = any slot due.
  - out_tag and out_late come from the lowest-index due slot; out_tag=0 and out_late=0 when none is due.
  - Fixed priority is by slot index, not by age.
- Pop: out_valid && out_ready at an edge clears occ of the selected slot only.
  - Other due slots keep occ=1 and have late set to 1.
  - Any due slot not popped at an edge gets late=1.
- out_valid/out_tag/out_late stay stable while out_valid=1 and out_ready=0, unless a lower-index slot becomes due. The tag may then switch; a due event is never dropped.
- busy_cnt = popcount(occ), registered-state based.
- Simultaneous accept and pop at the same edge: both take effect; busy_cnt is unchanged.
- Full: all occ=1 gives in_ready=0. in_valid is ignored, with no state change; the source must hold.
- Flush:
  - flush high at an edge clears all occ/late.
  - Any accept or pop in that cycle has no effect.
  - in_ready=0 while flush=1. out_valid may still be high during the flush cycle, but a pop there is discarded.
- Reset mid-operation: all pending events are discarded; no output is produced for them after reset.
- in_delay at max value (2^DLY_W-1) is legal; it is due 2^DLY_W-1 cycles after the accept edge.

Test Plan:
- Reset: rst high 10 cycles, release → in_ready=1, out_valid=0, busy_cnt=0. Events issued during rst produce no output.
- Single event: accept D=5, tag=3 at edge k, out_ready=1 → out_valid=1, out_tag=3 only in the cycle after edge k+5; busy_cnt returns 0.
- Fill and full: with SLOTS=4, accept D=20 tags 1..4 on consecutive edges → in_ready=0, busy_cnt=4. A 5th request is held; it is accepted at the edge after the first pop (tag 1 due at its k+20).
- Collision: accept tag=7 D=3 into slot0 and tag=9 D=2 into slot1 on the next edge, out_ready=0 → both due same cycle, out_tag=7, out_late=0. Following cycle out_late=1. Raise out_ready → tag 7 then tag 9 on consecutive cycles, tag 9 with out_late=1.
- Back-to-back D=0: in_valid held with D=0, out_ready=1 → each event appears one cycle after acceptance. Steady state uses ≤2 slots, with accept and pop on the same edge.
- Flush: 3 events pending (D=10), assert flush one cycle → busy_cnt=0 next cycle, no out_valid ever for those tags. in_ready=0 during the flush cycle.

Source files
------------

// File: rtl/latency_sched.sv
// Programmable-delay event scheduler: each accepted event waits its own
// delay in a slot, then is presented on a valid/ready port by slot priority.
module latency_sched #(
    parameter int SLOTS = 4,
    parameter int DLY_W = 8,
    parameter int TAG_W = 4
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DLY_W-1:0]           in_delay,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_late,
    output logic [$clog2(SLOTS+1)-1:0] busy_cnt
);

    localparam int CW = $clog2(SLOTS + 1);

    logic [SLOTS-1:0] occ_q, occ_d;
    logic [SLOTS-1:0] late_q, late_d;
    logic [DLY_W-1:0] cnt_q [SLOTS];
    logic [DLY_W-1:0] cnt_d [SLOTS];
    logic [TAG_W-1:0] tag_q [SLOTS];
    logic [TAG_W-1:0] tag_d [SLOTS];

    logic [SLOTS-1:0] due;
    logic [SLOTS-1:0] sel_oh;
    logic [SLOTS-1:0] free_oh;
    logic             found_due;
    logic             found_free;
    logic [CW-1:0]    busy_w;
    logic             pop;
    logic             acc;

    // One-hot pickers keep the lowest-index due slot and lowest free slot.
    always_comb begin
        due        = '0;
        sel_oh     = '0;
        free_oh    = '0;
        found_due  = 1'b0;
        found_free = 1'b0;
        busy_w     = '0;
        for (int i = 0; i < SLOTS; i++) begin
            due[i] = occ_q[i] && (cnt_q[i] == '0);
            busy_w = busy_w + CW'(occ_q[i]);
            if (due[i] && !found_due) begin
                sel_oh[i] = 1'b1;
                found_due = 1'b1;
            end
            if (!occ_q[i] && !found_free) begin
                free_oh[i] = 1'b1;
                found_free = 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = !rst && found_due;
        out_tag   = '0;
        out_late  = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (sel_oh[i] && !rst) begin
                out_tag  = tag_q[i];
                out_late = late_q[i];
            end
        end
        in_ready = !rst && !flush && found_free;
        busy_cnt = rst ? '0 : busy_w;
        pop      = out_valid && out_ready && !flush;
        acc      = in_valid && in_ready;
    end

    always_comb begin
        occ_d  = occ_q;
        late_d = late_q;
        cnt_d  = cnt_q;
        tag_d  = tag_q;
        for (int i = 0; i < SLOTS; i++) begin
            if (occ_q[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - DLY_W'(1);
            end
            if (due[i]) begin
                if (pop && sel_oh[i]) begin
                    occ_d[i] = 1'b0;
                end else begin
                    late_d[i] = 1'b1;
                end
            end
            // Target slot is free in registered state, so it never collides with a pop.
            if (acc && free_oh[i]) begin
                occ_d[i]  = 1'b1;
                cnt_d[i]  = in_delay;
                tag_d[i]  = in_tag;
                late_d[i] = 1'b0;
            end
        end
        if (flush) begin
            occ_d  = '0;
            late_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            occ_q  <= '0;
            late_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                cnt_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            occ_q  <= occ_d;
            late_q <= late_d;
            for (int i = 0; i < SLOTS; i++) begin
                cnt_q[i] <= cnt_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

endmodule
